// File: rtl/ctrl_pipe_stall_if.sv
// ctrl_pipe_stall_if: bundle of the decoder-side inputs, hazard/dmem controls
// and the per-stage control outputs of the ID->EX->MEM->WB control chain.
// master drives the decoded fields and hazard/dmem signals, slave is the chain.
interface ctrl_pipe_stall_if #(
    parameter int W_EX  = 12,
    parameter int W_MEM = 5,
    parameter int W_WB  = 3
);
    logic [W_EX-1:0]  Di_ex;
    logic [W_MEM-1:0] Di_mem;
    logic [W_WB-1:0]  Di_wb;
    logic             Di_valid;
    logic             Di_stall;
    logic             Ei_flush;
    logic             Mi_memReady;

    logic [W_EX-1:0]  Eo_ex;
    logic [W_WB-1:0]  Eo_wb;
    logic [W_MEM-1:0] Mo_mem;
    logic [W_WB-1:0]  Mo_wb;
    logic [W_WB-1:0]  Wo_wb;
    logic             Eo_valid;
    logic             Mo_valid;
    logic             Wo_valid;
    logic             o_holdFD;
    logic [31:0]      o_stallCycles;
    logic [31:0]      o_bubbleCount;

    modport master (
        output Di_ex, Di_mem, Di_wb, Di_valid, Di_stall, Ei_flush, Mi_memReady,
        input  Eo_ex, Eo_wb, Mo_mem, Mo_wb, Wo_wb, Eo_valid, Mo_valid, Wo_valid,
        input  o_holdFD, o_stallCycles, o_bubbleCount
    );

    modport slave (
        input  Di_ex, Di_mem, Di_wb, Di_valid, Di_stall, Ei_flush, Mi_memReady,
        output Eo_ex, Eo_wb, Mo_mem, Mo_wb, Wo_wb, Eo_valid, Mo_valid, Wo_valid,
        output o_holdFD, o_stallCycles, o_bubbleCount
    );
endinterface

// File: rtl/ctrl_pipe_stall.sv
// ctrl_pipe_stall: ID/EX, EX/MEM, MEM/WB control-register chain with load-use
// bubble insertion, a sticky EX flush that survives a dmem wait, and a dmem
// ready handshake that freezes E/M and drains a bubble into W.
// Optional performance counters are built only when CTRL_PIPE_PERF_EN is
// defined; otherwise both counter outputs are tied to zero.
module ctrl_pipe_stall #(
    parameter int W_EX       = 12,
    parameter int W_MEM      = 5,
    parameter int W_WB       = 3,
    parameter int MEMREQ_IDX = 3
) (
    input  logic            clk,
    input  logic            reset_x,
    ctrl_pipe_stall_if.slave bus
);
    logic [W_EX-1:0]  e_ex_q,  e_ex_d;
    logic [W_MEM-1:0] e_mem_q, e_mem_d;
    logic [W_WB-1:0]  e_wb_q,  e_wb_d;
    logic             e_vld_q, e_vld_d;
    logic [W_MEM-1:0] m_mem_q, m_mem_d;
    logic [W_WB-1:0]  m_wb_q,  m_wb_d;
    logic             m_vld_q, m_vld_d;
    logic [W_WB-1:0]  w_wb_q,  w_wb_d;
    logic             w_vld_q, w_vld_d;
    logic             flush_pend_q, flush_pend_d;

    logic mem_wait;
    logic hold_fd;
    logic e_bubble;

    // A valid memory op in M without ready freezes the front of the pipe.
    assign mem_wait = m_vld_q & m_mem_q[MEMREQ_IDX] & ~bus.Mi_memReady;
    assign hold_fd  = mem_wait | bus.Di_stall;

    // Next-state selection: memWait hold beats bubble insertion beats normal advance.
    always_comb begin
        e_ex_d       = e_ex_q;
        e_mem_d      = e_mem_q;
        e_wb_d       = e_wb_q;
        e_vld_d      = e_vld_q;
        m_mem_d      = m_mem_q;
        m_wb_d       = m_wb_q;
        m_vld_d      = m_vld_q;
        w_wb_d       = m_wb_q;
        w_vld_d      = m_vld_q;
        flush_pend_d = 1'b0;
        e_bubble     = 1'b0;
        if (mem_wait) begin
            // E and M hold; a flush arriving now must still kill whatever
            // ID presents on the release edge, so remember it.
            w_wb_d       = '0;
            w_vld_d      = 1'b0;
            flush_pend_d = flush_pend_q | bus.Ei_flush;
        end else begin
            e_bubble = bus.Ei_flush | flush_pend_q | bus.Di_stall;
            m_mem_d  = e_mem_q;
            m_wb_d   = e_wb_q;
            m_vld_d  = e_vld_q;
            if (e_bubble) begin
                e_ex_d  = '0;
                e_mem_d = '0;
                e_wb_d  = '0;
                e_vld_d = 1'b0;
            end else begin
                // Invalid slots carry zero fields so memReq/regWrite stay low.
                e_ex_d  = bus.Di_valid ? bus.Di_ex  : '0;
                e_mem_d = bus.Di_valid ? bus.Di_mem : '0;
                e_wb_d  = bus.Di_valid ? bus.Di_wb  : '0;
                e_vld_d = bus.Di_valid;
            end
        end
    end

    // Stage registers; reset discards every in-flight slot and the pending flush.
    always_ff @(posedge clk) begin
        if (!reset_x) begin
            e_ex_q       <= '0;
            e_mem_q      <= '0;
            e_wb_q       <= '0;
            e_vld_q      <= 1'b0;
            m_mem_q      <= '0;
            m_wb_q       <= '0;
            m_vld_q      <= 1'b0;
            w_wb_q       <= '0;
            w_vld_q      <= 1'b0;
            flush_pend_q <= 1'b0;
        end else begin
            e_ex_q       <= e_ex_d;
            e_mem_q      <= e_mem_d;
            e_wb_q       <= e_wb_d;
            e_vld_q      <= e_vld_d;
            m_mem_q      <= m_mem_d;
            m_wb_q       <= m_wb_d;
            m_vld_q      <= m_vld_d;
            w_wb_q       <= w_wb_d;
            w_vld_q      <= w_vld_d;
            flush_pend_q <= flush_pend_d;
        end
    end

`ifdef CTRL_PIPE_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] bubble_cnt_q;
    logic [1:0]  bubble_inc;

    // E bubbles and W drain bubbles are counted separately and may add up.
    assign bubble_inc = {1'b0, e_bubble} + {1'b0, mem_wait};

    // Free-running wrap-around counters of hold cycles and inserted bubbles.
    always_ff @(posedge clk) begin
        if (!reset_x) begin
            stall_cnt_q  <= 32'd0;
            bubble_cnt_q <= 32'd0;
        end else begin
            if (hold_fd) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            bubble_cnt_q <= bubble_cnt_q + {30'd0, bubble_inc};
        end
    end

    assign bus.o_stallCycles = stall_cnt_q;
    assign bus.o_bubbleCount = bubble_cnt_q;
`else
    assign bus.o_stallCycles = 32'd0;
    assign bus.o_bubbleCount = 32'd0;
`endif

    assign bus.Eo_ex    = e_ex_q;
    assign bus.Eo_wb    = e_wb_q;
    assign bus.Eo_valid = e_vld_q;
    assign bus.Mo_mem   = m_mem_q;
    assign bus.Mo_wb    = m_wb_q;
    assign bus.Mo_valid = m_vld_q;
    assign bus.Wo_wb    = w_wb_q;
    assign bus.Wo_valid = w_vld_q;
    assign bus.o_holdFD = hold_fd;

endmodule

// File: tb/tb_ctrl_pipe_stall.sv
// tb_ctrl_pipe_stall: directed scenarios plus randomized traffic checked
// against a slot-level reference model of the control chain.
module tb_ctrl_pipe_stall;
    localparam int W_EX = 12;
    localparam int W_MEM = 5;
    localparam int W_WB = 3;
    localparam int MEMREQ_IDX = 3;

    logic clk;
    logic reset_x;

    ctrl_pipe_stall_if #(.W_EX(W_EX), .W_MEM(W_MEM), .W_WB(W_WB)) bus ();

    ctrl_pipe_stall #(.W_EX(W_EX), .W_MEM(W_MEM), .W_WB(W_WB), .MEMREQ_IDX(MEMREQ_IDX)) dut (
        .clk    (clk),
        .reset_x(reset_x),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [W_EX-1:0]  ex;
        logic [W_MEM-1:0] mem;
        logic [W_WB-1:0]  wb;
        logic             v;
    } slot_t;

    // Reference model: one instruction slot per stage plus the pending flush.
    slot_t       sE = '0, sM = '0, sW = '0;
    bit          pend = 1'b0;
    logic [31:0] st_cnt = 32'd0, bub_cnt = 32'd0;

    int n_checks = 0;
    int n_errors = 0;

    function automatic bit model_wait();
        return sM.v && sM.mem[MEMREQ_IDX] && !bus.Mi_memReady;
    endfunction

    // Advance the model and the DUT by one edge; inputs are sampled before the edge.
    task automatic tick();
        slot_t in_s;
        bit    w, ebub, hold;
        w    = model_wait();
        hold = w || bus.Di_stall;
        ebub = !w && (bus.Ei_flush || pend || bus.Di_stall);
        in_s = bus.Di_valid ? slot_t'({bus.Di_ex, bus.Di_mem, bus.Di_wb, 1'b1}) : slot_t'('0);
        @(posedge clk);
        if (!reset_x) begin
            sE = '0; sM = '0; sW = '0; pend = 1'b0;
            st_cnt = 32'd0; bub_cnt = 32'd0;
        end else begin
`ifdef CTRL_PIPE_PERF_EN
            if (hold) st_cnt = st_cnt + 32'd1;
            bub_cnt = bub_cnt + 32'(ebub) + 32'(w);
`endif
            if (w) begin
                sW = '0;
                pend = pend || bus.Ei_flush;
            end else begin
                sW = sM;
                sM = sE;
                sE = ebub ? slot_t'('0) : in_s;
                pend = 1'b0;
            end
        end
        #1;
    endtask

    task automatic drive(input logic v, input logic [W_EX-1:0] ex, input logic [W_MEM-1:0] mem,
                         input logic [W_WB-1:0] wb, input logic stall, input logic flush, input logic rdy);
        bus.Di_valid = v; bus.Di_ex = ex; bus.Di_mem = mem; bus.Di_wb = wb;
        bus.Di_stall = stall; bus.Ei_flush = flush; bus.Mi_memReady = rdy;
    endtask

    task automatic test_reset();
        reset_x = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(1'($urandom), 12'($urandom), 5'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            tick();
        end
        n_checks++;
        if ({bus.Eo_ex, bus.Eo_wb, bus.Mo_mem, bus.Mo_wb, bus.Wo_wb} !== '0) begin
            n_errors++;
            $display("FAIL reset_fields got E=%h/%h M=%h/%h W=%h want all 0", bus.Eo_ex, bus.Eo_wb, bus.Mo_mem, bus.Mo_wb, bus.Wo_wb);
        end
        n_checks++;
        if ({bus.Eo_valid, bus.Mo_valid, bus.Wo_valid} !== 3'b000) begin
            n_errors++;
            $display("FAIL reset_valids got %b want 000", {bus.Eo_valid, bus.Mo_valid, bus.Wo_valid});
        end
        n_checks++;
        if (bus.o_stallCycles !== 32'd0 || bus.o_bubbleCount !== 32'd0) begin
            n_errors++;
            $display("FAIL reset_counters got %0d/%0d want 0/0", bus.o_stallCycles, bus.o_bubbleCount);
        end
        reset_x = 1'b1;
        drive(1'b1, 12'h5A5, 5'b00000, 3'b101, 1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b0, 12'h000, 5'b00000, 3'b000, 1'b0, 1'b0, 1'b1);
        tick();
        tick();
        n_checks++;
        if (bus.Wo_wb !== 3'b101 || bus.Wo_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_release_latency got wb=%b v=%b want wb=101 v=1", bus.Wo_wb, bus.Wo_valid);
        end
    endtask

    task automatic test_load_use();
        drive(1'b1, 12'h3C1, 5'b00101, 3'b011, 1'b1, 1'b0, 1'b1);
        #1;
        n_checks++;
        if (bus.o_holdFD !== 1'b1) begin
            n_errors++;
            $display("FAIL load_use_hold got %b want 1", bus.o_holdFD);
        end
        tick();
        n_checks++;
        if (bus.Eo_valid !== 1'b0 || bus.Eo_ex !== 12'h000) begin
            n_errors++;
            $display("FAIL load_use_bubble got v=%b ex=%h want v=0 ex=000", bus.Eo_valid, bus.Eo_ex);
        end
        bus.Di_stall = 1'b0;
        tick();
        n_checks++;
        if (bus.Eo_valid !== 1'b1 || bus.Eo_ex !== 12'h3C1 || bus.Eo_wb !== 3'b011) begin
            n_errors++;
            $display("FAIL load_use_enter got v=%b ex=%h wb=%b want v=1 ex=3c1 wb=011", bus.Eo_valid, bus.Eo_ex, bus.Eo_wb);
        end
    endtask

    task automatic test_flush();
        drive(1'b1, 12'h7E7, 5'b01000, 3'b111, 1'b0, 1'b1, 1'b1);
        tick();
        n_checks++;
        if (bus.Eo_valid !== 1'b0 || bus.Eo_ex !== 12'h000) begin
            n_errors++;
            $display("FAIL flush_e got v=%b ex=%h want v=0 ex=000", bus.Eo_valid, bus.Eo_ex);
        end
        drive(1'b0, 12'h000, 5'b00000, 3'b000, 1'b0, 1'b0, 1'b1);
        tick();
        n_checks++;
        if (bus.Mo_mem[MEMREQ_IDX] !== 1'b0 || bus.Mo_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL flush_m got memReq=%b v=%b want 0 0", bus.Mo_mem[MEMREQ_IDX], bus.Mo_valid);
        end
    endtask

    // Reset, then bring load L into M with instruction B behind it in E.
    task automatic setup_wait();
        reset_x = 1'b0;
        tick();
        reset_x = 1'b1;
        drive(1'b1, 12'h111, 5'b01010, 3'b011, 1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b1, 12'h222, 5'b00000, 3'b001, 1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b1, 12'h333, 5'b00000, 3'b110, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_mem_wait();
        logic [31:0] exp_st, exp_bub;
        setup_wait();
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++;
            if (bus.o_holdFD !== 1'b1) begin
                n_errors++;
                $display("FAIL wait_hold[%0d] got %b want 1", k, bus.o_holdFD);
            end
            tick();
            n_checks++;
            if (bus.Mo_mem !== 5'b01010 || bus.Eo_ex !== 12'h222 || bus.Wo_valid !== 1'b0) begin
                n_errors++;
                $display("FAIL wait_freeze[%0d] got mem=%b ex=%h wv=%b want 01010 222 0", k, bus.Mo_mem, bus.Eo_ex, bus.Wo_valid);
            end
        end
        bus.Mi_memReady = 1'b1;
        #1;
        n_checks++;
        if (bus.o_holdFD !== 1'b0) begin
            n_errors++;
            $display("FAIL wait_release_hold got %b want 0", bus.o_holdFD);
        end
        tick();
        n_checks++;
        if (bus.Wo_wb !== 3'b011 || bus.Wo_valid !== 1'b1 || bus.Eo_ex !== 12'h333 || bus.Mo_wb !== 3'b001) begin
            n_errors++;
            $display("FAIL wait_release got W=%b/%b E=%h M=%b want 011/1 333 001", bus.Wo_wb, bus.Wo_valid, bus.Eo_ex, bus.Mo_wb);
        end
`ifdef CTRL_PIPE_PERF_EN
        exp_st = 32'd3; exp_bub = 32'd3;
`else
        exp_st = 32'd0; exp_bub = 32'd0;
`endif
        n_checks++;
        if (bus.o_stallCycles !== exp_st || bus.o_bubbleCount !== exp_bub) begin
            n_errors++;
            $display("FAIL wait_perf got %0d/%0d want %0d/%0d", bus.o_stallCycles, bus.o_bubbleCount, exp_st, exp_bub);
        end
    endtask

    task automatic test_flush_during_wait();
        setup_wait();
        tick();
        bus.Ei_flush = 1'b1;
        tick();
        bus.Ei_flush = 1'b0;
        tick();
        bus.Mi_memReady = 1'b1;
        tick();
        n_checks++;
        if (bus.Eo_valid !== 1'b0 || bus.Eo_ex !== 12'h000 || bus.Mo_wb !== 3'b001 || bus.Wo_wb !== 3'b011) begin
            n_errors++;
            $display("FAIL fdw_bubble got Ev=%b Eex=%h Mwb=%b Wwb=%b want 0 000 001 011", bus.Eo_valid, bus.Eo_ex, bus.Mo_wb, bus.Wo_wb);
        end
        tick();
        n_checks++;
        if (bus.Eo_valid !== 1'b1 || bus.Eo_ex !== 12'h333) begin
            n_errors++;
            $display("FAIL fdw_pend_clear got v=%b ex=%h want 1 333", bus.Eo_valid, bus.Eo_ex);
        end
    endtask

    task automatic test_random();
        bit exp_hold;
        for (int i = 0; i < 600; i++) begin
            reset_x = ($urandom_range(0, 79) != 0);
            bus.Di_valid    = ($urandom_range(0, 3) != 0);
            bus.Di_ex       = 12'($urandom);
            bus.Di_mem      = 5'($urandom);
            bus.Di_wb       = 3'($urandom);
            bus.Di_stall    = ($urandom_range(0, 5) == 0);
            bus.Ei_flush    = ($urandom_range(0, 6) == 0);
            bus.Mi_memReady = ($urandom_range(0, 2) != 0);
            #1;
            exp_hold = model_wait() || bus.Di_stall;
            n_checks++;
            if (bus.o_holdFD !== exp_hold) begin
                n_errors++;
                $display("FAIL rnd_hold[%0d] got %b want %b", i, bus.o_holdFD, exp_hold);
            end
            tick();
            n_checks++;
            if (bus.Eo_ex !== sE.ex || bus.Eo_wb !== sE.wb || bus.Eo_valid !== sE.v) begin
                n_errors++;
                $display("FAIL rnd_E[%0d] got %h/%b/%b want %h/%b/%b", i, bus.Eo_ex, bus.Eo_wb, bus.Eo_valid, sE.ex, sE.wb, sE.v);
            end
            n_checks++;
            if (bus.Mo_mem !== sM.mem || bus.Mo_wb !== sM.wb || bus.Mo_valid !== sM.v) begin
                n_errors++;
                $display("FAIL rnd_M[%0d] got %b/%b/%b want %b/%b/%b", i, bus.Mo_mem, bus.Mo_wb, bus.Mo_valid, sM.mem, sM.wb, sM.v);
            end
            n_checks++;
            if (bus.Wo_wb !== sW.wb || bus.Wo_valid !== sW.v) begin
                n_errors++;
                $display("FAIL rnd_W[%0d] got %b/%b want %b/%b", i, bus.Wo_wb, bus.Wo_valid, sW.wb, sW.v);
            end
            n_checks++;
            if (bus.o_stallCycles !== st_cnt || bus.o_bubbleCount !== bub_cnt) begin
                n_errors++;
                $display("FAIL rnd_perf[%0d] got %0d/%0d want %0d/%0d", i, bus.o_stallCycles, bus.o_bubbleCount, st_cnt, bub_cnt);
            end
        end
        reset_x = 1'b1;
    endtask

    task automatic test_perf_wrap();
        reset_x = 1'b1;
        drive(1'b0, 12'h000, 5'b00000, 3'b000, 1'b1, 1'b0, 1'b1);
`ifdef CTRL_PIPE_PERF_EN
        force dut.stall_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.stall_cnt_q;
        #1;
        tick();
        n_checks++;
        if (bus.o_stallCycles !== 32'd0) begin
            n_errors++;
            $display("FAIL perf_wrap got %h want 00000000", bus.o_stallCycles);
        end
`else
        tick();
        n_checks++;
        if (bus.o_stallCycles !== 32'd0 || bus.o_bubbleCount !== 32'd0) begin
            n_errors++;
            $display("FAIL perf_tied got %0d/%0d want 0/0", bus.o_stallCycles, bus.o_bubbleCount);
        end
`endif
    endtask

    initial begin
        reset_x = 1'b0;
        drive(1'b0, 12'h000, 5'b00000, 3'b000, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        test_reset();
        test_load_use();
        test_flush();
        test_mem_wait();
        test_flush_during_wait();
        test_random();
        test_perf_wrap();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Safety net so a stuck run still ends with a visible failure.
    initial begin
        #200000;
        $display("FAIL timeout got no completion want finish");
        $fatal(1);
    end
endmodule
